tmds_encoder_mc: RTL

TMDS_ENCODER_MC -- requirements
Module: tmds_encoder_mc

---
 rtl/tmds_encoder_mc_if.sv | 22 ++
 rtl/tmds_encoder_mc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_mc_if.sv
// TMDS encoder bus: per-channel byte/ctrl/TERC4 inputs, period mode,
// per-channel 10-bit symbols out. master = source, slave = encoder.
interface tmds_encoder_mc_if #(
  parameter int NUM_CH = 3
);
  logic [8*NUM_CH-1:0]  pix_data;
  logic [1:0]           mode;
  logic [2*NUM_CH-1:0]  ctrl;
  logic [4*NUM_CH-1:0]  terc;
  logic [10*NUM_CH-1:0] q_out;
  logic                 q_valid;

  modport master (
    output pix_data, mode, ctrl, terc,
    input  q_out, q_valid
  );

  modport slave (
    input  pix_data, mode, ctrl, terc,
    output q_out, q_valid
  );
endinterface

// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS encoder, 2-stage pipeline (q_m, then symbol/disparity).
// Ports: clk, rst (sync, high), bus (slave: pix_data/mode/ctrl/terc in, q_out/q_valid out).
module tmds_encoder_mc #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  tmds_encoder_mc_if.slave bus
);
  typedef enum logic [1:0] {
    M_CTRL  = 2'b00,
    M_VIDEO = 2'b01,
    M_TERC  = 2'b10,
    M_GUARD = 2'b11
  } mode_e;

  typedef logic signed [CNT_W-1:0] cnt_t;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] GB_EVEN = 10'b1011001100;
  localparam logic [9:0] GB_ODD  = 10'b0100110011;

  function automatic logic [3:0] ones8(
    input logic [7:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] qm_of(
    input logic [7:0] d
  );
    logic [3:0] n1;
    logic       xn;
    logic [8:0] q;
    n1 = ones8(d);
    xn = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_sym(
    input logic [1:0] c
  );
    logic [9:0] s;
    unique case (c)
      2'b00: s = 10'b1101010100;
      2'b01: s = 10'b0010101011;
      2'b10: s = 10'b0101010100;
      2'b11: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc_sym(
    input logic [3:0] t
  );
    logic [9:0] s;
    unique case (t)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      4'hF: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Returns {symbol, next cnt}. diff is n1-n0 of q_m[7:0];
  // signs come from MSBs to keep compares signed.
  function automatic logic [10+CNT_W-1:0] video_enc(
    input logic [8:0] qm,
    input cnt_t       cnt
  );
    cnt_t       diff;
    cnt_t       nxt;
    logic [9:0] sym;
    logic       c_zero;
    logic       c_pos;
    logic       c_neg;
    logic       d_pos;
    logic       d_neg;
    diff   = (cnt_t'(ones8(qm[7:0])) <<< 1) - cnt_t'(8);
    c_zero = (cnt == '0);
    c_neg  = cnt[CNT_W-1];
    c_pos  = !c_neg && !c_zero;
    d_neg  = diff[CNT_W-1];
    d_pos  = !d_neg && (diff != '0);
    if (c_zero || diff == '0) begin
      sym = {~qm[8], qm[8],
             qm[8] ? qm[7:0] : ~qm[7:0]};
      nxt = qm[8] ? cnt + diff : cnt - diff;
    end else if ((c_pos && d_pos) ||
                 (c_neg && d_neg)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nxt = cnt + cnt_t'({qm[8], 1'b0}) - diff;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nxt = cnt + diff - cnt_t'({~qm[8], 1'b0});
    end
    return {sym, nxt};
  endfunction

  logic [8:0]          qm_s1 [NUM_CH];
  mode_e               mode_s1;
  logic [2*NUM_CH-1:0] ctrl_s1;
  logic [4*NUM_CH-1:0] terc_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_s1 <= M_CTRL;
      ctrl_s1 <= '0;
      terc_s1 <= '0;
      for (int k = 0; k < NUM_CH; k++)
        qm_s1[k] <= '0;
    end else begin
      mode_s1 <= mode_e'(bus.mode);
      ctrl_s1 <= bus.ctrl;
      terc_s1 <= bus.terc;
      for (int k = 0; k < NUM_CH; k++)
        qm_s1[k] <= qm_of(bus.pix_data[8*k +: 8]);
    end
  end

  cnt_t                 cnt_q [NUM_CH];
  cnt_t                 cnt_d [NUM_CH];
  logic [10*NUM_CH-1:0] q_d;

  // Non-video periods leave cnt_d at 0 so disparity restarts cleanly.
  always_comb begin
    q_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = '0;
      unique case (mode_s1)
        M_VIDEO:
          {q_d[10*k +: 10], cnt_d[k]} =
            video_enc(qm_s1[k], cnt_q[k]);
        M_TERC:
          q_d[10*k +: 10] =
            terc_sym(terc_s1[4*k +: 4]);
        M_GUARD:
          q_d[10*k +: 10] =
            (k % 2 == 0) ? GB_EVEN : GB_ODD;
        default:
          q_d[10*k +: 10] =
            ctrl_sym(ctrl_s1[2*k +: 2]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.q_out   <= {NUM_CH{CTRL_00}};
      bus.q_valid <= 1'b0;
      for (int k = 0; k < NUM_CH; k++)
        cnt_q[k] <= '0;
    end else begin
      bus.q_out   <= q_d;
      bus.q_valid <= (mode_s1 == M_VIDEO);
      for (int k = 0; k < NUM_CH; k++)
        cnt_q[k] <= cnt_d[k];
    end
  end
endmodule
